// File: rtl/uart_imem_loader_pkg.sv
// Shared definitions for the UART instruction-memory boot loader.
//   SYNC_BYTE     : frame start marker
//   LEN_W         : width of the frame word-count field
//   loader_state_t: frame FSM states
//   rx_state_t    : UART receiver FSM states
package uart_imem_loader_pkg;

    localparam logic [7:0]  SYNC_BYTE = 8'hA5;
    localparam int unsigned LEN_W     = 16;

    typedef enum logic [2:0] {
        LD_IDLE,
        LD_LEN_LO,
        LD_LEN_HI,
        LD_DATA,
        LD_CHK,
        LD_DONE
    } loader_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF synchroniser, bit timer and LSB-first shifter.
//   clk_i       : system clock
//   rst_i       : asynchronous active-high reset
//   rx_i        : serial line, idle high, asynchronous to clk_i
//   byte_o      : last received byte (valid with byte_vld_o)
//   byte_vld_o  : one-cycle pulse the cycle after a good mid-stop sample
//   frame_err_o : one-cycle pulse when the stop bit samples low
module uart_rx
    import uart_imem_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       byte_vld_o,
    output logic       frame_err_o
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic             sync1_q, rx_s_q, rx_prev_q;
    logic             rx_fall;
    rx_state_t        state_q, state_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [2:0]       bit_q, bit_n;
    logic [7:0]       shift_q, shift_n;
    logic             vld_q, vld_n;
    logic             ferr_q, ferr_n;

    assign rx_fall = rx_prev_q & ~rx_s_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q   <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            sync1_q   <= rx_i;
            rx_s_q    <= sync1_q;
            rx_prev_q <= rx_s_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            vld_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            bit_q   <= bit_n;
            shift_q <= shift_n;
            vld_q   <= vld_n;
            ferr_q  <= ferr_n;
        end
    end

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        bit_n   = bit_q;
        shift_n = shift_q;
        vld_n   = 1'b0;
        ferr_n  = 1'b0;
        unique case (state_q)
            RX_IDLE: begin
                if (rx_fall) begin
                    state_n = RX_START;
                    cnt_n   = '0;
                end
            end
            RX_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_n = '0;
                    bit_n = '0;
                    // A start bit that is high again at mid-bit was a glitch.
                    state_n = rx_s_q ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_n   = '0;
                    shift_n = {rx_s_q, shift_q[7:1]};
                    if (bit_q == 3'd7) state_n = RX_STOP;
                    else               bit_n   = bit_q + 1'b1;
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    state_n = RX_IDLE;
                    vld_n   = rx_s_q;
                    ferr_n  = ~rx_s_q;
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            default: state_n = RX_IDLE;
        endcase
    end

    assign byte_o      = shift_q;
    assign byte_vld_o  = vld_q;
    assign frame_err_o = ferr_q;

endmodule

// File: rtl/uart_imem_loader.sv
// Boot loader: receives a program frame over UART and writes it into imem.
// Frame: A5, LEN_LO, LEN_HI, 4*N data bytes (little-endian words), XOR checksum.
//   clk_i       : system clock
//   rst_i       : asynchronous active-high reset
//   uart_rx_i   : serial input, idle high
//   imem_we_o   : one-cycle write strobe per assembled word
//   imem_addr_o : word address (holds between writes)
//   imem_data_o : write data (holds between writes)
//   cpu_rst_o   : core reset request, released after a good load
//   busy_o      : high while a frame is in progress
//   err_o       : sticky framing / length / checksum error, cleared by next sync
module uart_imem_loader
    import uart_imem_loader_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned CLK_HZ    = 50000000,
    parameter int unsigned BAUD      = 115200,
    parameter int unsigned BOOT_HOLD = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              uart_rx_i,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [XLEN-1:0]   imem_data_o,
    output logic              cpu_rst_o,
    output logic              busy_o,
    output logic              err_o
);

    localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int unsigned LANES        = XLEN / 8;
    localparam int unsigned K_W          = $clog2(LANES);
    localparam logic [LEN_W:0] MAX_WORDS = (LEN_W + 1)'(2 ** ADDR_W);
    localparam logic CPU_RST_INIT        = (BOOT_HOLD != 0);

    logic [7:0] rx_byte;
    logic       rx_vld, rx_err;

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .rx_i       (uart_rx_i),
        .byte_o     (rx_byte),
        .byte_vld_o (rx_vld),
        .frame_err_o(rx_err)
    );

    loader_state_t     state_q, state_n;
    logic [7:0]        len_lo_q, len_lo_n;
    logic [LEN_W-1:0]  wcnt_q, wcnt_n;
    logic [XLEN-1:0]   word_q, word_n;
    logic [K_W-1:0]    lane_q, lane_n;
    logic [ADDR_W-1:0] idx_q, idx_n;
    logic [7:0]        xor_q, xor_n;
    logic              we_q, we_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [XLEN-1:0]   data_q, data_n;
    logic              busy_q, busy_n;
    logic              err_q, err_n;
    logic              cpu_rst_q, cpu_rst_n;
    logic [LEN_W-1:0]  n_len;

    assign n_len = {rx_byte, len_lo_q};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= LD_IDLE;
            len_lo_q  <= '0;
            wcnt_q    <= '0;
            word_q    <= '0;
            lane_q    <= '0;
            idx_q     <= '0;
            xor_q     <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            cpu_rst_q <= CPU_RST_INIT;
        end else begin
            state_q   <= state_n;
            len_lo_q  <= len_lo_n;
            wcnt_q    <= wcnt_n;
            word_q    <= word_n;
            lane_q    <= lane_n;
            idx_q     <= idx_n;
            xor_q     <= xor_n;
            we_q      <= we_n;
            addr_q    <= addr_n;
            data_q    <= data_n;
            busy_q    <= busy_n;
            err_q     <= err_n;
            cpu_rst_q <= cpu_rst_n;
        end
    end

    always_comb begin
        state_n   = state_q;
        len_lo_n  = len_lo_q;
        wcnt_n    = wcnt_q;
        word_n    = word_q;
        lane_n    = lane_q;
        idx_n     = idx_q;
        xor_n     = xor_q;
        we_n      = 1'b0;
        addr_n    = addr_q;
        data_n    = data_q;
        busy_n    = busy_q;
        err_n     = err_q;
        cpu_rst_n = cpu_rst_q;
        if (rx_err) begin
            // Framing error aborts the frame in any state; core reset untouched.
            state_n = LD_IDLE;
            err_n   = 1'b1;
            busy_n  = 1'b0;
        end else if (rx_vld) begin
            unique case (state_q)
                LD_IDLE, LD_DONE: begin
                    if (rx_byte == SYNC_BYTE) begin
                        state_n   = LD_LEN_LO;
                        busy_n    = 1'b1;
                        cpu_rst_n = 1'b1;
                        err_n     = 1'b0;
                        idx_n     = '0;
                        xor_n     = '0;
                        lane_n    = '0;
                    end
                end
                LD_LEN_LO: begin
                    len_lo_n = rx_byte;
                    state_n  = LD_LEN_HI;
                end
                LD_LEN_HI: begin
                    if ({1'b0, n_len} > MAX_WORDS) begin
                        state_n = LD_IDLE;
                        err_n   = 1'b1;
                        busy_n  = 1'b0;
                    end else if (n_len == '0) begin
                        state_n = LD_CHK;
                    end else begin
                        wcnt_n  = n_len;
                        state_n = LD_DATA;
                    end
                end
                LD_DATA: begin
                    xor_n = xor_q ^ rx_byte;
                    word_n[{lane_q, 3'b000} +: 8] = rx_byte;
                    lane_n = lane_q + 1'b1;
                    if (lane_q == K_W'(LANES - 1)) begin
                        we_n   = 1'b1;
                        data_n = word_n;
                        addr_n = idx_q;
                        idx_n  = idx_q + 1'b1;
                        wcnt_n = wcnt_q - 1'b1;
                        if (wcnt_q == LEN_W'(1)) state_n = LD_CHK;
                    end
                end
                LD_CHK: begin
                    busy_n = 1'b0;
                    if (rx_byte == xor_q) begin
                        state_n   = LD_DONE;
                        cpu_rst_n = 1'b0;
                    end else begin
                        state_n = LD_IDLE;
                        err_n   = 1'b1;
                    end
                end
                default: state_n = LD_IDLE;
            endcase
        end
    end

    assign imem_we_o   = we_q;
    assign imem_addr_o = addr_q;
    assign imem_data_o = data_q;
    assign cpu_rst_o   = cpu_rst_q;
    assign busy_o      = busy_q;
    assign err_o       = err_q;

endmodule
